// File: rtl/spi_slv_pkg.sv
// Shared types and helpers for the SPI mode-0 slave responder.
package spi_slv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } spi_slv_state_t;

    localparam int SPI_SLV_DATA_W_DEF = 8;

    // Bit position of the idx-th bit on the wire for the chosen ordering.
    function automatic int bit_sel(input int idx, input bit msb_first,
                                   input int width = SPI_SLV_DATA_W_DEF);
        if (msb_first) begin
            return width - 1 - idx;
        end else begin
            return idx;
        end
    endfunction

endpackage

// File: rtl/spi_slv_sync.sv
// N-stage input synchronizer with rise/fall detection on the synchronized level.
module spi_slv_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_r;
    logic              prev_r;

    // Synchronizer chain plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (!reset) begin
            chain_r <= {STAGES{RST_VAL}};
            prev_r  <= RST_VAL;
        end else begin
            chain_r <= {chain_r[STAGES-2:0], din};
            prev_r  <= chain_r[STAGES-1];
        end
    end

    assign dout = chain_r[STAGES-1];
    assign rise = chain_r[STAGES-1] & ~prev_r;
    assign fall = ~chain_r[STAGES-1] & prev_r;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave: oversampled receive, single-entry transmit holding register.
// Define SPI_SLV_ECHO_EN to echo the last received frame on transmit underrun.
module spi_slave_responder
    import spi_slv_pkg::*;
#(
    parameter int DATA_W      = SPI_SLV_DATA_W_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int MSB_FIRST   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              cs_bar,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_done,
    output logic              frame_err,
    output logic              busy
);

    localparam int               CNT_W     = $clog2(DATA_W + 1);
    localparam int               FIRST_IDX = bit_sel(0, MSB_FIRST != 0, DATA_W);
    localparam int               NEXT_IDX  = bit_sel(1, MSB_FIRST != 0, DATA_W);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DATA_W);

    spi_slv_state_t    state_r, state_nx_s;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic [DATA_W-1:0] rx_shift_r, tx_shift_r, hold_r, rx_data_r, load_val_s;
    logic tx_ready_r, miso_r, rx_valid_r, tx_done_r, frame_err_r, busy_r;
    logic sclk_rise_s, sclk_fall_s, cs_s, cs_rise_s, cs_fall_s, mosi_s;
    logic sclk_lvl_unused_s, mosi_rise_unused_s, mosi_fall_unused_s;
    logic load_s, rise_s, fall_s, done_s, abort_s;

    spi_slv_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .reset(reset), .din(sclk),
        .dout(sclk_lvl_unused_s), .rise(sclk_rise_s), .fall(sclk_fall_s));

    spi_slv_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk(clk), .reset(reset), .din(cs_bar),
        .dout(cs_s), .rise(cs_rise_s), .fall(cs_fall_s));

    spi_slv_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .reset(reset), .din(mosi),
        .dout(mosi_s), .rise(mosi_rise_unused_s), .fall(mosi_fall_unused_s));

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next state and per-clock datapath strobes; deselect overrides everything.
    always_comb begin
        state_nx_s = state_r;
        load_s     = 1'b0;
        rise_s     = 1'b0;
        fall_s     = 1'b0;
        done_s     = 1'b0;
        abort_s    = 1'b0;
        if (cs_rise_s) begin
            state_nx_s = IDLE;
            abort_s    = (bit_cnt_r != {CNT_W{1'b0}});
        end else begin
            case (state_r)
                IDLE: begin
                    if (cs_fall_s) begin
                        state_nx_s = LOAD;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                LOAD: begin
                    load_s     = 1'b1;
                    state_nx_s = SHIFT;
                end
                SHIFT: begin
                    if (bit_cnt_r == CNT_FULL) begin
                        done_s     = 1'b1;
                        state_nx_s = LOAD;
                    end else begin
                        rise_s = sclk_rise_s;
                        // The fall trailing a frame's last bit must not disturb the next byte.
                        fall_s = sclk_fall_s && (bit_cnt_r != {CNT_W{1'b0}});
                    end
                end
                default: begin
                    state_nx_s = IDLE;
                end
            endcase
        end
    end

    // Byte presented at the start of a frame: holding register, or the underrun value.
    always_comb begin
        if (tx_ready_r) begin
`ifdef SPI_SLV_ECHO_EN
            load_val_s = rx_data_r;
`else
            load_val_s = {DATA_W{1'b0}};
`endif
        end else begin
            load_val_s = hold_r;
        end
    end

    // Shift registers, bit counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bit_cnt_r   <= {CNT_W{1'b0}};
            rx_shift_r  <= {DATA_W{1'b0}};
            tx_shift_r  <= {DATA_W{1'b0}};
            rx_data_r   <= {DATA_W{1'b0}};
            miso_r      <= 1'b0;
            rx_valid_r  <= 1'b0;
            tx_done_r   <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            rx_valid_r  <= 1'b0;
            tx_done_r   <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= ~cs_s;
            if (cs_rise_s) begin
                bit_cnt_r   <= {CNT_W{1'b0}};
                miso_r      <= 1'b0;
                frame_err_r <= abort_s;
            end else if (load_s) begin
                tx_shift_r <= load_val_s;
                miso_r     <= load_val_s[FIRST_IDX];
            end else if (done_s) begin
                rx_data_r  <= rx_shift_r;
                rx_valid_r <= 1'b1;
                tx_done_r  <= 1'b1;
                bit_cnt_r  <= {CNT_W{1'b0}};
            end else if (rise_s) begin
                bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                if (MSB_FIRST != 0) begin
                    rx_shift_r <= {rx_shift_r[DATA_W-2:0], mosi_s};
                end else begin
                    rx_shift_r <= {mosi_s, rx_shift_r[DATA_W-1:1]};
                end
            end else if (fall_s) begin
                miso_r <= tx_shift_r[NEXT_IDX];
                if (MSB_FIRST != 0) begin
                    tx_shift_r <= {tx_shift_r[DATA_W-2:0], 1'b0};
                end else begin
                    tx_shift_r <= {1'b0, tx_shift_r[DATA_W-1:1]};
                end
            end
        end
    end

    // Holding register handshake; a frame consuming the register wins over a new load.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hold_r     <= {DATA_W{1'b0}};
            tx_ready_r <= 1'b1;
        end else if (load_s && !tx_ready_r) begin
            tx_ready_r <= 1'b1;
        end else if (tx_load && tx_ready_r) begin
            hold_r     <= tx_data;
            tx_ready_r <= 1'b0;
        end
    end

    assign miso      = miso_r;
    assign tx_ready  = tx_ready_r;
    assign rx_data   = rx_data_r;
    assign rx_valid  = rx_valid_r;
    assign tx_done   = tx_done_r;
    assign frame_err = frame_err_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Randomized scoreboard bench for spi_slave_responder; honours SPI_SLV_ECHO_EN.
module tb_spi_slave_responder;

    localparam int DW   = 8;
    localparam int SS   = 2;
    localparam int MSBF = 1;
    localparam int IW   = $clog2(DW);

    logic          clk = 1'b0, reset = 1'b0, sclk = 1'b0, cs_bar = 1'b1, mosi = 1'b0;
    logic          tx_load = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          miso, tx_ready, rx_valid, tx_done, frame_err, busy;
    logic [DW-1:0] rx_data;

    spi_slave_responder #(.DATA_W(DW), .SYNC_STAGES(SS), .MSB_FIRST(MSBF)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .cs_bar(cs_bar), .mosi(mosi),
        .miso(miso), .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_done(tx_done),
        .frame_err(frame_err), .busy(busy));

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    int done_cnt = 0, ferr_cnt = 0, exp_frames = 0, exp_aborts = 0;
    logic [DW-1:0] exp_rx_q[$], exp_tx_q[$], obs_tx_q[$];

    // Reference model: holding register contents and last completed receive.
    bit            ref_full = 1'b0;
    logic [DW-1:0] ref_hold = '0, ref_last_rx = '0, cur_exp = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [IW-1:0] pos(input int k);
        return IW'((MSBF != 0) ? (DW - 1 - k) : k);
    endfunction

    function automatic logic [DW-1:0] underrun_val();
`ifdef SPI_SLV_ECHO_EN
        return ref_last_rx;
`else
        return '0;
`endif
    endfunction

    function automatic logic [DW-1:0] consume();
        if (ref_full) begin
            ref_full = 1'b0;
            return ref_hold;
        end
        return underrun_val();
    endfunction

    task automatic do_load(input logic [DW-1:0] v);
        check("tx_ready_before_load", {31'd0, tx_ready}, {31'd0, !ref_full});
        tx_data = v;
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
        if (!ref_full) begin
            ref_full = 1'b1;
            ref_hold = v;
        end
        check("tx_ready_after_load", {31'd0, tx_ready}, 32'd0);
    endtask

    // Select the slave; optionally strobe tx_load on the very clock the frame loads.
    task automatic frame_start(input bit bnd, input logic [DW-1:0] v);
        cs_bar = 1'b0;
        if (bnd) begin
            tick(3);
            tx_data = v;
            tx_load = 1'b1;
            cur_exp = consume();
            if (!ref_full) begin
                ref_full = 1'b1;
                ref_hold = v;
            end
            tick(1);
            tx_load = 1'b0;
            tick(2);
            check("tx_ready_boundary", {31'd0, tx_ready}, {31'd0, !ref_full});
        end else begin
            cur_exp = consume();
            tick(6);
        end
        check("busy_selected", {31'd0, busy}, 32'd1);
    endtask

    task automatic frame_end(input bit aborted);
        cs_bar = 1'b1;
        if (aborted) exp_aborts++;
        tick(6);
        check("busy_deselected", {31'd0, busy}, 32'd0);
        check("miso_deselected", {31'd0, miso}, 32'd0);
    endtask

    // Master side of one byte: mosi changes with sclk low, miso sampled at the rise.
    task automatic send_byte(input logic [DW-1:0] b, input int nbits,
                             input bit mid_load, input logic [DW-1:0] mv);
        logic [DW-1:0] exp_tx, got;
        exp_tx = cur_exp;
        got    = '0;
        for (int k = 0; k < nbits; k++) begin
            mosi = b[pos(k)];
            tick(4);
            got[pos(k)] = miso;
            if (k == DW - 1) begin
                exp_rx_q.push_back(b);
                exp_tx_q.push_back(exp_tx);
                obs_tx_q.push_back(got);
                ref_last_rx = b;
                exp_frames++;
            end
            sclk = 1'b1;
            tick(4);
            sclk = 1'b0;
            if (k == DW - 1) cur_exp = consume();
            if (mid_load && k == 1) do_load(mv);
        end
    endtask

    // Monitor: every rx_valid pulse retires one expected receive/transmit pair.
    always @(negedge clk) begin
        if (reset) begin
            if (rx_valid) begin
                if (exp_rx_q.size() == 0) begin
                    check("rx_valid_unexpected", {31'd0, rx_valid}, 32'd0);
                end else begin
                    check("rx_data", {24'd0, rx_data}, {24'd0, exp_rx_q.pop_front()});
                    check("miso_byte", {24'd0, obs_tx_q.pop_front()}, {24'd0, exp_tx_q.pop_front()});
                end
            end
            if (tx_done) done_cnt++;
            if (frame_err) ferr_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] r1, r2;
        tick(3);
        reset = 1'b1;
        tick(2);

        // Reset mid-activity with a byte pending in the holding register.
        do_load(8'h77);
        frame_start(1'b0, '0);
        send_byte(8'h96, 3, 1'b1, 8'h66);
        reset  = 1'b0;
        cs_bar = 1'b1;
        sclk   = 1'b0;
        tick(3);
        check("rst_miso", {31'd0, miso}, 32'd0);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_tx_done", {31'd0, tx_done}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        ref_full = 1'b0;
        ref_last_rx = '0;
        tick(4);

        // Single frame: A5 out, 3C in.
        do_load(8'hA5);
        frame_start(1'b0, '0);
        send_byte(8'h3C, DW, 1'b0, '0);
        frame_end(1'b0);

        // Back-to-back bytes under one select; second byte loaded mid-frame.
        do_load(8'h5A);
        frame_start(1'b0, '0);
        send_byte(8'h12, DW, 1'b1, 8'hC3);
        send_byte(8'hE7, DW, 1'b0, '0);
        frame_end(1'b0);

        // Underrun after receiving 81.
        frame_start(1'b0, '0);
        send_byte(8'h81, DW, 1'b0, '0);
        frame_end(1'b0);
        frame_start(1'b0, '0);
        send_byte(8'h4B, DW, 1'b0, '0);
        frame_end(1'b0);

        // Deselect after 5 bits, then a clean frame.
        frame_start(1'b0, '0);
        send_byte(8'hF0, 5, 1'b0, '0);
        frame_end(1'b1);
        check("rx_data_held_after_abort", {24'd0, rx_data}, {24'd0, ref_last_rx});
        frame_start(1'b0, '0);
        send_byte(8'h2D, DW, 1'b0, '0);
        frame_end(1'b0);

        // Second load while full is ignored.
        do_load(8'h11);
        do_load(8'h22);
        frame_start(1'b0, '0);
        send_byte(8'h6E, DW, 1'b0, '0);
        frame_end(1'b0);

        // Load strobed on the same clock the frame consumes the register.
        frame_start(1'b1, 8'h4D);
        send_byte(8'hB1, DW, 1'b0, '0);
        send_byte(8'h1B, DW, 1'b0, '0);
        frame_end(1'b0);

        // Randomized frames.
        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(0, 1) == 1) do_load(DW'($urandom));
            frame_start(1'b0, '0);
            for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
                r1 = DW'($urandom);
                r2 = DW'($urandom);
                send_byte(r1, DW, ($urandom_range(0, 1) == 1), r2);
            end
            frame_end(1'b0);
        end

        tick(20);
        check("rx_queue_drained", exp_rx_q.size(), 32'd0);
        check("tx_done_count", done_cnt, exp_frames);
        check("frame_err_count", ferr_cnt, exp_aborts);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
